// File: rtl/tx_frontend_pkg.sv
// tx_frontend_pkg: register map offsets, datapath widths and 24-bit saturation
// helpers shared by the tx_frontend pipeline.
package tx_frontend_pkg;

  localparam int REG_DC_I  = 0;
  localparam int REG_DC_Q  = 1;
  localparam int REG_MAG   = 2;
  localparam int REG_PHASE = 3;
  localparam int REG_SWAP  = 4;

  localparam int IW = 24;  // internal sample width
  localparam int CW = 18;  // correction coefficient width

  typedef logic signed [IW-1:0] sample_t;

  typedef struct packed {
    logic    vld;
    sample_t i;
    sample_t q;
  } stage_t;

  // Sign-extended 25-bit sum of two samples; the carry bit exposes overflow.
  function automatic logic [IW:0] wide_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
    return {a[IW-1], a} + {b[IW-1], b};
  endfunction

  function automatic logic sat_ovf(input logic [IW:0] x);
    return x[IW] ^ x[IW-1];
  endfunction

  function automatic sample_t sat_clip(input logic [IW:0] x);
    if (x[IW] ^ x[IW-1])
      return x[IW] ? sample_t'({1'b1, {(IW-1){1'b0}}}) : sample_t'({1'b0, {(IW-1){1'b1}}});
    return sample_t'(x[IW-1:0]);
  endfunction

endpackage

// File: rtl/round_and_clip.sv
// round_and_clip: round-half-up a signed WIDTH_IN sample to WIDTH_OUT bits and
// saturate; clip flags when saturation was needed. Requires WIDTH_OUT < WIDTH_IN.
module round_and_clip #(
  parameter int WIDTH_IN  = 24,
  parameter int WIDTH_OUT = 16
) (
  input  logic signed [WIDTH_IN-1:0]  din,
  output logic signed [WIDTH_OUT-1:0] dout,
  output logic                        clip
);

  localparam int SH = WIDTH_IN - WIDTH_OUT;
  localparam logic [WIDTH_IN:0] HALF = (WIDTH_IN + 1)'(1) << (SH - 1);

  logic [WIDTH_IN:0]  sum;
  logic [WIDTH_OUT:0] shr;
  logic               unused_lsb;

  assign sum        = {din[WIDTH_IN-1], din} + HALF;
  assign shr        = sum[WIDTH_IN:SH];
  assign unused_lsb = ^sum[SH-1:0];

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    clip = shr[WIDTH_OUT] ^ shr[WIDTH_OUT-1];
    dout = shr[WIDTH_OUT-1:0];
    if (clip)
      dout = shr[WIDTH_OUT] ? {1'b1, {(WIDTH_OUT-1){1'b0}}} : {1'b0, {(WIDTH_OUT-1){1'b1}}};
  end

endmodule

// File: rtl/tx_frontend.sv
// tx_frontend: TX DAC front end -- optional IQ-imbalance correction, DC offset,
// rounding/saturation and IQ swap. Define TX_FRONTEND_IQCOMP_EN for IQ correction.
module tx_frontend
  import tx_frontend_pkg::*;
#(
  parameter int BASE      = 0,
  parameter int WIDTH_OUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set_stb,
  input  logic [7:0]                  set_addr,
  input  logic [31:0]                 set_data,
  input  logic signed [IW-1:0]        i_in,
  input  logic signed [IW-1:0]        q_in,
  input  logic                        in_stb,
  input  logic                        run,
  output logic signed [WIDTH_OUT-1:0] dac_a,
  output logic signed [WIDTH_OUT-1:0] dac_b,
  output logic                        out_stb,
  output logic [31:0]                 debug
);

  sample_t dc_i, dc_q;
  logic    swap_iq, clip_i, clip_q;
  logic    wr_dc_i, wr_dc_q, wr_swap, unused_data;

  assign wr_dc_i     = set_stb && (set_addr == 8'(BASE + REG_DC_I));
  assign wr_dc_q     = set_stb && (set_addr == 8'(BASE + REG_DC_Q));
  assign wr_swap     = set_stb && (set_addr == 8'(BASE + REG_SWAP));
  assign unused_data = ^set_data[31:24];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_i    <= '0;
      dc_q    <= '0;
      swap_iq <= 1'b0;
    end else begin
      if (wr_dc_i) dc_i <= set_data[IW-1:0];
      if (wr_dc_q) dc_q <= set_data[IW-1:0];
      if (wr_swap) swap_iq <= set_data[0];
    end
  end

  // Stage 1: capture; run=0 substitutes zero baseband so DC calibration still flows.
  stage_t s1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1 <= '0;
    else     s1 <= '{vld: in_stb, i: run ? i_in : '0, q: run ? q_in : '0};
  end

  stage_t pre_dc;
  logic   clip3_i, clip3_q;

`ifdef TX_FRONTEND_IQCOMP_EN
  logic signed [CW-1:0]   mag_corr, phase_corr;
  logic signed [2*CW-1:0] corr_i, corr_q;
  logic [IW:0]            sum3_i, sum3_q;
  stage_t                 s2, s3;
  logic                   unused_corr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_corr   <= '0;
      phase_corr <= '0;
    end else begin
      if (set_stb && (set_addr == 8'(BASE + REG_MAG)))   mag_corr   <= set_data[CW-1:0];
      if (set_stb && (set_addr == 8'(BASE + REG_PHASE))) phase_corr <= set_data[CW-1:0];
    end
  end

  // Stage 2: both corrections are driven by the I sample (gain on I, leakage into Q).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2     <= '0;
      corr_i <= '0;
      corr_q <= '0;
    end else begin
      s2     <= s1;
      corr_i <= (2*CW)'($signed(s1.i[IW-1 -: CW])) * (2*CW)'(mag_corr);
      corr_q <= (2*CW)'($signed(s1.i[IW-1 -: CW])) * (2*CW)'(phase_corr);
    end
  end

  assign sum3_i      = wide_add(s2.i, corr_i[2*CW-1 -: IW]);
  assign sum3_q      = wide_add(s2.q, corr_q[2*CW-1 -: IW]);
  assign clip3_i     = s2.vld & sat_ovf(sum3_i);
  assign clip3_q     = s2.vld & sat_ovf(sum3_q);
  assign unused_corr = ^{corr_i[2*CW-IW-1:0], corr_q[2*CW-IW-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s3 <= '0;
    else     s3 <= '{vld: s2.vld, i: sat_clip(sum3_i), q: sat_clip(sum3_q)};
  end

  assign pre_dc = s3;
`else
  assign pre_dc  = s1;
  assign clip3_i = 1'b0;
  assign clip3_q = 1'b0;
`endif

  // Stage 4: DC offset for LO-leakage cancellation.
  logic [IW:0] sum4_i, sum4_q;
  stage_t      s4;

  assign sum4_i = wide_add(pre_dc.i, dc_i);
  assign sum4_q = wide_add(pre_dc.q, dc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s4 <= '0;
    else     s4 <= '{vld: pre_dc.vld, i: sat_clip(sum4_i), q: sat_clip(sum4_q)};
  end

  // Stage 5: round to DAC width; outputs hold between strobes.
  logic signed [WIDTH_OUT-1:0] rnd_i, rnd_q;
  logic                        clip5_i, clip5_q;

  round_and_clip #(.WIDTH_IN(IW), .WIDTH_OUT(WIDTH_OUT)) u_rnd_i (
    .din(s4.i), .dout(rnd_i), .clip(clip5_i)
  );
  round_and_clip #(.WIDTH_IN(IW), .WIDTH_OUT(WIDTH_OUT)) u_rnd_q (
    .din(s4.q), .dout(rnd_q), .clip(clip5_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_stb <= 1'b0;
      dac_a   <= '0;
      dac_b   <= '0;
    end else begin
      out_stb <= s4.vld;
      if (s4.vld) begin
        dac_a <= swap_iq ? rnd_q : rnd_i;
        dac_b <= swap_iq ? rnd_i : rnd_q;
      end
    end
  end

  // Sticky per-channel clip flags (pre-swap channel naming); swap write clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_i <= 1'b0;
      clip_q <= 1'b0;
    end else if (wr_swap) begin
      clip_i <= 1'b0;
      clip_q <= 1'b0;
    end else begin
      clip_i <= clip_i | clip3_i | (pre_dc.vld & sat_ovf(sum4_i)) | (s4.vld & clip5_i);
      clip_q <= clip_q | clip3_q | (pre_dc.vld & sat_ovf(sum4_q)) | (s4.vld & clip5_q);
    end
  end

  // debug: [31] out_stb, [30] run, [29] swap_iq, [28] clip_i, [27] clip_q.
  assign debug = {out_stb, run, swap_iq, clip_i, clip_q, 27'b0};

endmodule

// File: tb/tb_tx_frontend.sv
// tb_tx_frontend: directed + randomized bench for tx_frontend against an
// integer-arithmetic reference model with a latency scoreboard.
module tb_tx_frontend;

  localparam int W    = 16;
  localparam int BASE = 0;
`ifdef TX_FRONTEND_IQCOMP_EN
  localparam int LAT = 5;
  localparam bit IQC = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit IQC = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b0, set_stb = 1'b0, in_stb = 1'b0, run = 1'b0;
  logic [7:0]   set_addr = '0;
  logic [31:0]  set_data = '0;
  logic [23:0]  i_in = '0, q_in = '0;
  logic [W-1:0] dac_a, dac_b;
  logic         out_stb;
  logic [31:0]  debug;

  tx_frontend #(.BASE(BASE), .WIDTH_OUT(W)) dut (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_in(i_in), .q_in(q_in), .in_stb(in_stb), .run(run),
    .dac_a(dac_a), .dac_b(dac_b), .out_stb(out_stb), .debug(debug)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         stb;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t         sb[$];
  longint       m_dc_i, m_dc_q, m_mag, m_phase;
  logic         m_swap, m_ci, m_cq;
  logic [W-1:0] last_a, last_b;
  int           n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int bits, output logic ov);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    ov = (v > hi) || (v < lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    return 32'($signed(v << (32 - bits)) >>> (32 - bits));
  endfunction

  // Expected DAC words for one input sample, from the arithmetic definition.
  task automatic push_sample(input logic stb, input logic [23:0] iv, input logic [23:0] qv,
                             input logic r);
    longint i, q, i0, ra, rb;
    logic   o1, o2, o3, o4, o5, o6;
    exp_t   e;
    i  = r ? longint'($signed(iv)) : 64'sd0;
    q  = r ? longint'($signed(qv)) : 64'sd0;
    i0 = i;
    o1 = 1'b0;
    o2 = 1'b0;
    if (IQC) begin
      i = sat(i + (((i0 >>> 6) * m_mag) >>> 12), 24, o1);
      q = sat(q + (((i0 >>> 6) * m_phase) >>> 12), 24, o2);
    end
    i  = sat(i + m_dc_i, 24, o3);
    q  = sat(q + m_dc_q, 24, o4);
    ra = sat((i + (longint'(1) <<< (23 - W))) >>> (24 - W), W, o5);
    rb = sat((q + (longint'(1) <<< (23 - W))) >>> (24 - W), W, o6);
    if (stb) begin
      m_ci = m_ci | o1 | o3 | o5;
      m_cq = m_cq | o2 | o4 | o6;
    end
    e.stb = stb;
    e.a   = m_swap ? rb[W-1:0] : ra[W-1:0];
    e.b   = m_swap ? ra[W-1:0] : rb[W-1:0];
    sb.push_back(e);
  endtask

  task automatic step(input logic stb, input logic [23:0] iv, input logic [23:0] qv,
                      input logic r);
    exp_t e;
    in_stb = stb;
    i_in   = iv;
    q_in   = qv;
    run    = r;
    push_sample(stb, iv, qv, r);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.stb) begin
      last_a = e.a;
      last_b = e.b;
    end
    check("out_stb", 32'(out_stb), 32'(e.stb));
    check("dac_a", 32'(dac_a), 32'(last_a));
    check("dac_b", 32'(dac_b), 32'(last_b));
  endtask

  task automatic drain();
    repeat (LAT + 1) step(1'b0, 24'h0, 24'h0, run);
  endtask

  task automatic write_reg(input int off, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = 8'(BASE + off);
    set_data = d;
    step(1'b0, 24'h0, 24'h0, run);
    set_stb  = 1'b0;
    case (off)
      0: m_dc_i = longint'($signed(d[23:0]));
      1: m_dc_q = longint'($signed(d[23:0]));
      2: if (IQC) m_mag = longint'($signed(d[17:0]));
      3: if (IQC) m_phase = longint'($signed(d[17:0]));
      4: begin
        m_swap = d[0];
        m_ci   = 1'b0;
        m_cq   = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    exp_t idle;
    m_dc_i  = 0;
    m_dc_q  = 0;
    m_mag   = 0;
    m_phase = 0;
    m_swap  = 1'b0;
    m_ci    = 1'b0;
    m_cq    = 1'b0;
    last_a  = '0;
    last_b  = '0;
    idle    = '0;
    sb.delete();
    repeat (LAT - 1) sb.push_back(idle);
  endtask

  // Asserts reset away from the clock edge and checks the asynchronous clear.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    check("rst_async_stb", 32'(out_stb), 32'h0);
    check("rst_async_a", 32'(dac_a), 32'h0);
    check("rst_async_b", 32'(dac_b), 32'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_stb", 32'(out_stb), 32'h0);
      check("rst_dac", 32'({dac_a, dac_b}), 32'h0);
      check("rst_debug", debug, {1'b0, run, 30'b0});
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] ri, rq;
    model_reset();
    reset_pulse();

    // All registers zero, unity path.
    step(1'b1, 24'h010000, 24'hFF0000, 1'b1);
    drain();
    check("base_a", 32'(dac_a), 32'h0100);
    check("base_b", 32'(dac_b), 32'hFF00);

    // Channel swap.
    write_reg(4, 32'h1);
    step(1'b1, 24'h010000, 24'hFF0000, 1'b1);
    drain();
    check("swap_a", 32'(dac_a), 32'hFF00);
    check("swap_b", 32'(dac_b), 32'h0100);
    check("swap_dbg", 32'(debug[29]), 32'h1);

    // run=0 passes only the rounded DC offset.
    write_reg(4, 32'h0);
    write_reg(0, 32'h000100);
    step(1'b1, 24'($urandom), 24'($urandom), 1'b0);
    drain();
    check("dc_only_a", 32'(dac_a), 32'h0001);
    check("dc_only_b", 32'(dac_b), 32'h0000);
    write_reg(0, 32'h0);

`ifdef TX_FRONTEND_IQCOMP_EN
    // Gain correction pushes I past full scale.
    write_reg(2, 32'h01000);
    step(1'b1, 24'h7F0000, 24'h000000, 1'b1);
    drain();
    check("iq_sat_a", 32'(dac_a), 32'h7FFF);
    check("iq_clip_i", 32'(debug[28]), 32'h1);
    check("iq_clip_q", 32'(debug[27]), 32'h0);
    write_reg(2, 32'h0);
`else
    // Correction registers are absent: writes have no effect.
    write_reg(2, 32'h01000);
    write_reg(3, 32'h00ABC);
    step(1'b1, 24'h010000, 24'hFF0000, 1'b1);
    drain();
    check("nocomp_a", 32'(dac_a), 32'h0100);
    check("nocomp_b", 32'(dac_b), 32'hFF00);
`endif
    write_reg(4, 32'h0);
    check("clip_clear", 32'(debug[28:27]), 32'h0);

    // Randomized rounds; round 0 stays small so no stage saturates.
    for (int r = 0; r < 3; r++) begin
      write_reg(0, (r == 0) ? sx($urandom, 12) : $urandom);
      write_reg(1, (r == 0) ? sx($urandom, 12) : $urandom);
      write_reg(2, (r == 0) ? sx($urandom, 10) : $urandom);
      write_reg(3, (r == 0) ? sx($urandom, 10) : $urandom);
      write_reg(4, {31'b0, 1'($urandom)});
      for (int k = 0; k < 150; k++) begin
        ri = 24'($urandom);
        rq = 24'($urandom);
        if (r == 0) begin
          ri = 24'(sx(32'(ri), 20));
          rq = 24'(sx(32'(rq), 20));
        end
        step(1'($urandom), ri, rq, $urandom_range(0, 7) != 0);
      end
      drain();
      check("rnd_clip_flags", 32'(debug[28:27]), 32'({m_ci, m_cq}));
      check("rnd_swap_dbg", 32'(debug[29]), 32'(m_swap));
    end

    // Strobe pattern 1,0,1,1 then reset while samples are in flight.
    write_reg(4, 32'h0);
    step(1'b1, 24'h020000, 24'h030000, 1'b1);
    step(1'b0, 24'h0, 24'h0, 1'b1);
    step(1'b1, 24'h040000, 24'hFC0000, 1'b1);
    step(1'b1, 24'h050000, 24'hFB0000, 1'b1);
    repeat (LAT - 2) step(1'b0, 24'h0, 24'h0, 1'b1);
    reset_pulse();
    repeat (LAT + 2) step(1'b0, 24'h0, 24'h0, 1'b1);
    step(1'b1, 24'h010000, 24'hFF0000, 1'b1);
    drain();
    check("post_rst_a", 32'(dac_a), 32'h0100);
    check("post_rst_b", 32'(dac_b), 32'hFF00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
